// File: rtl/the_pkg.sv
// ----------------------------------------------------------------------------
// the_pkg
//   Shared MIPS decode definitions: instruction field positions, opcode and
//   field types, instruction format and queue-state enums, helper functions.
// ----------------------------------------------------------------------------
package the_pkg;

    // Instruction field bit positions
    localparam int unsigned OP_MSB   = 31;
    localparam int unsigned OP_LSB   = 26;
    localparam int unsigned RS_MSB   = 25;
    localparam int unsigned RS_LSB   = 21;
    localparam int unsigned RT_MSB   = 20;
    localparam int unsigned RT_LSB   = 16;
    localparam int unsigned RD_MSB   = 15;
    localparam int unsigned RD_LSB   = 11;
    localparam int unsigned SA_MSB   = 10;
    localparam int unsigned SA_LSB   = 6;
    localparam int unsigned FN_MSB   = 5;
    localparam int unsigned FN_LSB   = 0;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned TARGET_W = 26;

    typedef logic [4:0] RegInBits;
    typedef logic [4:0] saBits;
    typedef logic [5:0] func_code;

    typedef enum logic [5:0] {
        OP_RTYPE  = 6'h00,
        OP_REGIMM = 6'h01,
        OP_J      = 6'h02,
        OP_JAL    = 6'h03,
        OP_BEQ    = 6'h04,
        OP_BNE    = 6'h05,
        OP_BLEZ   = 6'h06,
        OP_BGTZ   = 6'h07,
        OP_ADDI   = 6'h08,
        OP_ADDIU  = 6'h09,
        OP_SLTI   = 6'h0A,
        OP_SLTIU  = 6'h0B,
        OP_ANDI   = 6'h0C,
        OP_ORI    = 6'h0D,
        OP_XORI   = 6'h0E,
        OP_LUI    = 6'h0F,
        OP_LB     = 6'h20,
        OP_LH     = 6'h21,
        OP_LW     = 6'h23,
        OP_LBU    = 6'h24,
        OP_LHU    = 6'h25,
        OP_SB     = 6'h28,
        OP_SH     = 6'h29,
        OP_SW     = 6'h2B
    } op_code;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2
    } instr_fmt_t;

    typedef enum logic [1:0] {
        Q_EMPTY   = 2'd0,
        Q_PARTIAL = 2'd1,
        Q_FULL    = 2'd2
    } q_state_t;

    function automatic logic is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    // True when the raw opcode is one of the op_code members.
    function automatic logic op_is_member(input logic [5:0] v);
        case (v)
            OP_RTYPE, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ,
            OP_BGTZ, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
            OP_XORI, OP_LUI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB,
            OP_SH, OP_SW: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_fifo.sv
// ----------------------------------------------------------------------------
// decode_fifo
//   DEPTH-entry instruction/PC queue with valid/ready on both sides and a
//   synchronous flush. Ready/valid derive only from the occupancy count.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     i_flush               clear count and pointers at the edge
//     i_push_valid/o_push_ready, i_ins, i_pc    write side
//     o_pop_valid/i_pop_ready, o_head_ins, o_head_pc  read side (head entry)
// ----------------------------------------------------------------------------
module decode_fifo
    import the_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_push_valid,
    output logic            o_push_ready,
    input  logic [N-1:0]    i_ins,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_pop_valid,
    input  logic            i_pop_ready,
    output logic [N-1:0]    o_head_ins,
    output logic [PC_W-1:0] o_head_pc
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [N-1:0]    r_ins_mem [DEPTH];
    logic [PC_W-1:0] r_pc_mem  [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    q_state_t w_state;
    logic     w_push;
    logic     w_pop;

    always_comb begin
        w_state = Q_PARTIAL;
        if (r_count == '0)
            w_state = Q_EMPTY;
        else if (r_count == CW'(DEPTH))
            w_state = Q_FULL;
    end

    assign o_push_ready = (w_state != Q_FULL);
    assign o_pop_valid  = (w_state != Q_EMPTY);
    assign w_push       = i_push_valid & o_push_ready;
    assign w_pop        = i_pop_ready  & o_pop_valid;

    assign o_head_ins   = r_ins_mem[r_rd_ptr];
    assign o_head_pc    = r_pc_mem[r_rd_ptr];

    // DEPTH is a power of two, so pointer wrap is the natural AW-bit overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_ins_mem[i] <= '0;
                r_pc_mem[i]  <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_ins_mem[r_wr_ptr] <= i_ins;
                r_pc_mem[r_wr_ptr]  <= i_pc;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/decode_queue_stage.sv
// ----------------------------------------------------------------------------
// decode_queue_stage
//   Decode stage between fetch and register read. Fetched instructions and
//   their PCs are queued in decode_fifo; the head entry is split into fields,
//   classified (R/I/J), its immediate extended and its jump target formed.
//   All decoded outputs, out_pc and illegal read 0 while out_valid is low.
//   Optional: `DECODE_ILLEGAL_CHK_EN flags heads whose opcode is not an
//   op_code member; without it illegal is tied to 0.
//   Ports:
//     clk, rst_n, flush                       clock, async reset, queue clear
//     in_valid/in_ready, in_ins, in_pc        fetch side
//     out_valid/out_ready                     consumer side
//     op, func, rs, rt, rd, sa                instruction fields
//     imm_ext, jtarget, fmt, out_pc, illegal  decode results for the head
// ----------------------------------------------------------------------------
module decode_queue_stage
    import the_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_ins,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output op_code          op,
    output func_code        func,
    output RegInBits        rs,
    output RegInBits        rt,
    output RegInBits        rd,
    output saBits           sa,
    output logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] jtarget,
    output instr_fmt_t      fmt,
    output logic [PC_W-1:0] out_pc,
    output logic            illegal
);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_depth_chk
        $error("decode_queue_stage: DEPTH must be a power of two and >= 2");
    end

    logic [N-1:0]     w_ins;
    logic [PC_W-1:0]  w_head_pc;
    logic             w_valid;
    logic [5:0]       w_op_raw;
    logic [15:0]      w_imm16;
    logic [31:0]      w_lui;
    logic [3:0]       w_pc4_hi;
    logic [31:0]      w_jt32;
    logic [XLEN-1:0]  w_imm_ext;
    instr_fmt_t       w_fmt;
    logic             w_illegal;

    decode_fifo #(
        .N     (N),
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (flush),
        .i_push_valid (in_valid),
        .o_push_ready (in_ready),
        .i_ins        (in_ins),
        .i_pc         (in_pc),
        .o_pop_valid  (w_valid),
        .i_pop_ready  (out_ready),
        .o_head_ins   (w_ins),
        .o_head_pc    (w_head_pc)
    );

    assign out_valid = w_valid;
    assign w_op_raw  = w_ins[OP_MSB:OP_LSB];
    assign w_imm16   = w_ins[IMM_W-1:0];
    assign w_lui     = {w_imm16, 16'h0000};

    // Only the top nibble of pc+4 is needed; the carry out of the low bits
    // still has to propagate, hence the full-width add before the shift.
    assign w_pc4_hi  = 4'((w_head_pc + PC_W'(4)) >> (PC_W - 4));
    assign w_jt32    = {w_pc4_hi, w_ins[TARGET_W-1:0], 2'b00};

    always_comb begin
        case (w_op_raw)
            OP_ANDI, OP_ORI, OP_XORI: w_imm_ext = XLEN'(w_imm16);
            OP_LUI:                   w_imm_ext = XLEN'(w_lui);
            default:                  w_imm_ext = {{(XLEN-16){w_imm16[15]}}, w_imm16};
        endcase
    end

    always_comb begin
        case (w_op_raw)
            OP_RTYPE:      w_fmt = FMT_R;
            OP_J, OP_JAL:  w_fmt = FMT_J;
            default:       w_fmt = FMT_I;
        endcase
    end

`ifdef DECODE_ILLEGAL_CHK_EN
    assign w_illegal = !op_is_member(w_op_raw);
`else
    assign w_illegal = 1'b0;
`endif

    always_comb begin
        op      = OP_RTYPE;
        func    = '0;
        rs      = '0;
        rt      = '0;
        rd      = '0;
        sa      = '0;
        imm_ext = '0;
        jtarget = '0;
        fmt     = FMT_R;
        out_pc  = '0;
        illegal = 1'b0;
        if (w_valid) begin
            op      = op_code'(w_op_raw);
            func    = w_ins[FN_MSB:FN_LSB];
            rs      = w_ins[RS_MSB:RS_LSB];
            rt      = w_ins[RT_MSB:RT_LSB];
            rd      = w_ins[RD_MSB:RD_LSB];
            sa      = w_ins[SA_MSB:SA_LSB];
            imm_ext = w_imm_ext;
            jtarget = XLEN'(w_jt32);
            fmt     = w_fmt;
            out_pc  = w_head_pc;
            illegal = w_illegal;
        end
    end

endmodule

// File: doc/decode_queue_stage.md
Name: decode_queue_stage

Overview:
- Parametrised decode stage between fetch and register read in the MIPS datapath.
- Buffers fetched instructions and their PCs in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Splits the FIFO head into fields and classifies its format.
- Extends the immediate per opcode and computes the jump target; supports a pipeline flush.

Parameters:
- N, 32: instruction width; fields follow the_pkg bit positions.
- PC_W, 32: PC width.
- XLEN, 32: width of the extended immediate and jump target (XLEN >= 18).
- DEPTH, 2: FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous queue clear.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue can accept.
- in_ins  in  N  raw instruction.
- in_pc  in  PC_W  PC of in_ins.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- op  out  op_code  ins[31:26].
- func  out  func_code  ins[5:0].
- rs, rt, rd  out  RegInBits  ins[25:21], ins[20:16], ins[15:11].
- sa  out  saBits  ins[10:6].
- imm_ext  out  XLEN  extended immediate.
- jtarget  out  XLEN  jump target.
- fmt  out  instr_fmt_t  FMT_R / FMT_I / FMT_J.
- out_pc  out  PC_W  PC of head.
- illegal  out  1  unknown opcode.

Behaviour:
- Clock, reset and handshake conventions:
  - Single clock domain: clk.
  - rst_n is asynchronous and active-low; deassertion is synchronised externally.
  - Push when in_valid & in_ready; pop when out_valid & out_ready.
  - in_ready = (count != DEPTH); out_valid = (count != 0). Neither depends combinationally on in_valid or out_ready.
- Latency:
  - An entry pushed at edge t is visible on the outputs after edge t.
  - There is no same-cycle bypass.
- Queue state, derived from count (0..DEPTH):
  - EMPTY (count=0), PARTIAL, FULL (count=DEPTH).
  - Push only: count+1. Pop only: count-1.
  - Push and pop in the same cycle (PARTIAL only): count unchanged, both pointers advance.
  - FULL with out_ready: pop only, since in_ready is low.
  - Pointers wrap modulo DEPTH.
- Flush:
  - At the edge: count, rd_ptr and wr_ptr clear to 0.
  - Flush overrides a simultaneous push and pop; the pushed instruction is discarded.
  - out_valid=0 the cycle after flush.
- Reset, mid-operation included: count, pointers and storage cleared; in_ready=1, out_valid=0.
- Outputs are decoded combinationally from the head entry. When out_valid=0, every decoded output, out_pc and illegal are forced to 0.
- imm_ext, from ins[15:0]:
  - ANDI(0x0C), ORI(0x0D), XORI(0x0E): zero-extend to XLEN.
  - LUI(0x0F): {imm,16'b0}, zero-extended to XLEN.
  - All other opcodes: sign-extend.
- jtarget = {pc4[PC_W-1:PC_W-4], ins[25:0], 2'b00}, where pc4 = out_pc+4. The result is truncated or zero-extended to XLEN.
- fmt:
  - op=0x00 -> FMT_R.
  - op=0x02 or 0x03 -> FMT_J.
  - otherwise FMT_I.

Optional Feature:
- Macro: DECODE_ILLEGAL_CHK_EN.
- Defined: illegal=1 when out_valid is high and op is not a member of op_code. The entry still pops normally.
- Not defined: illegal is tied to 0 and no membership logic is built.

Decomposition:
- the_pkg gains:
  - instr_fmt_t (2-bit enum).
  - OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_J, OP_JAL constants, where op_code does not already provide them.
  - The DEPTH power-of-two check, as a function.
- One sub-module, decode_fifo: storage, pointers, count and flush.
- The top level holds field extraction, extension, jtarget and fmt.

Test Plan:
- Reset then single push: push ins=0x2128FFFC (ADDI rs=9, rt=8, imm=-4), pc=0x00400000, out_ready=1. Next cycle: out_valid=1, fmt=FMT_I, rs=9, rt=8, imm_ext=0xFFFFFFFC, out_pc=0x00400000. Cycle after: out_valid=0.
- Zero-extension and LUI:
  - ORI imm 0x8001 -> imm_ext=0x00008001.
  - LUI imm 0x1234 -> imm_ext=0x12340000.
- Jump: J ins=0x08100004 at pc=0x40000000 -> fmt=FMT_J, jtarget=0x40400010.
- Fill and backpressure, DEPTH=2:
  - out_ready=0, push 3 instructions: in_ready=0 after the 2nd; the 3rd is held by fetch.
  - Raise out_ready: order is preserved, and the 3rd is accepted the cycle after the first pop.
- Simultaneous push, pop and flush:
  - count=1 with push+pop: count stays 1.
  - Flush together with push: out_valid=0 next cycle and the pushed instruction never appears.
- Async reset mid-stream: assert rst_n=0 between edges with count=2 -> out_valid=0 and in_ready=1 immediately. With DECODE_ILLEGAL_CHK_EN defined, op=0x3F -> illegal=1.
